sram_ctrl: RTL

- Sequencing master for the external asynchronous SRAM data bus.
- Accepts single-word read/write requests from the Hack memory map and generates the SRAM control strobes: address, chip select, output enable and write enable.
- Controls the 16-bit tristate pin buffer through its direction and write-data inputs, and captures the buffer's read-back data.
- Sits between the memory-mapped I/O decode and the top-level tristate buffer instance.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding and sizing constants for the SRAM sequencer
package sram_pkg;

    localparam int CNT_W               = 4;
    localparam int DEFAULT_WAIT_CYCLES = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        R_ACCESS = 3'd1,
        W_SETUP  = 3'd2,
        W_PULSE  = 3'd3,
        W_HOLD   = 3'd4
    } state_e;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-word read/write sequencer driving async SRAM strobes
// and the direction/data side of the top-level tristate pin buffer.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_drive,
    output logic              sram_csx,
    output logic              sram_oex,
    output logic              sram_wex
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   sram_dout_q, sram_dout_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                drive_q, drive_d;
    logic                csx_q, csx_d;
    logic                oex_q, oex_d;
    logic                wex_q, wex_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sram_addr_q <= '0;
            sram_dout_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            drive_q     <= 1'b0;
            csx_q       <= 1'b1;
            oex_q       <= 1'b1;
            wex_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sram_addr_q <= sram_addr_d;
            sram_dout_q <= sram_dout_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            drive_q     <= drive_d;
            csx_q       <= csx_d;
            oex_q       <= oex_d;
            wex_q       <= wex_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sram_addr_d = sram_addr_q;
        sram_dout_d = sram_dout_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        drive_d     = drive_q;
        csx_d       = csx_q;
        oex_d       = oex_q;
        wex_d       = wex_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    sram_addr_d = addr;
                    cnt_d       = '0;
                    csx_d       = 1'b0;
                    if (we) begin
                        sram_dout_d = wdata;
                        state_d     = W_SETUP;
                        drive_d     = 1'b1;
                        wex_d       = 1'b1;
                    end else begin
                        state_d     = R_ACCESS;
                        drive_d     = 1'b0;
                        oex_d       = 1'b0;
                    end
                end
            end
            R_ACCESS: begin
                if (cnt_q == WAIT_LAST) begin
                    rdata_d  = sram_din;
                    rvalid_d = 1'b1;
                    csx_d    = 1'b1;
                    oex_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            W_SETUP: begin
                wex_d   = 1'b0;
                cnt_d   = '0;
                state_d = W_PULSE;
            end
            W_PULSE: begin
                if (cnt_q == WAIT_LAST) begin
                    wex_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = W_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            W_HOLD: begin
                // data stays driven one cycle past the wex rising edge
                csx_d   = 1'b1;
                drive_d = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                csx_d   = 1'b1;
                oex_d   = 1'b1;
                wex_d   = 1'b1;
                drive_d = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign ready      = (state_q == IDLE);
    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dout  = sram_dout_q;
    assign sram_drive = drive_q;
    assign sram_csx   = csx_q;
    assign sram_oex   = oex_q;
    assign sram_wex   = wex_q;

endmodule
